sub_d_pack: RTL and testbench

SUB_D_PACK -- requirements
Module: sub_d_pack

---
 rtl/sub_d_pkg.sv | 29 ++
 rtl/sub_d_satcnt.sv | 33 +++
 rtl/sub_d_pack.sv | 125 ++++++++++++
 tb/tb_sub_d_pack.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_d_pkg.sv
// Shared types and constants for the 2-bit-to-byte packer.
package sub_d_pkg;

  localparam int unsigned SLOTS_PER_BYTE = 4;
  localparam int unsigned SLOT_W         = 2;
  localparam int unsigned BYTE_W         = SLOTS_PER_BYTE * SLOT_W;
  localparam int unsigned SLOT_IDX_W     = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFill = 2'd1,
    StHold = 2'd2
  } pack_state_e;

  // Returns acc with slot idx overwritten by sample; other slots untouched.
  function automatic logic [BYTE_W-1:0] place_slot(input logic [BYTE_W-1:0]     acc,
                                                   input logic [SLOT_IDX_W-1:0] idx,
                                                   input logic [SLOT_W-1:0]     sample);
    logic [BYTE_W-1:0] r;
    r = acc;
    for (int k = 0; k < int'(SLOTS_PER_BYTE); k++) begin
      if (idx == SLOT_IDX_W'(k)) begin
        r[k*SLOT_W +: SLOT_W] = sample;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sub_d_satcnt.sv
// Saturating event counter with synchronous clear taking priority over increment.
module sub_d_satcnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/sub_d_pack.sv
// Packs four 2-bit samples into a byte with valid/ready handshake and an event counter.
// Optional parity output enabled by SUB_D_PACK_PARITY_EN.
module sub_d_pack
  import sub_d_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             testi_vld_d,
  output logic             testo_rdy_d,
  input  logic             testi1_d,
  input  logic             testi2_d,
  input  logic             testi3_d,
  input  logic             testi_clr_d,
  output logic [7:0]       testo_data_d,
  output logic             testo_vld_d,
  input  logic             testi_rdy_d,
  output logic [CNT_W-1:0] testo_cnt_d
`ifdef SUB_D_PACK_PARITY_EN
  ,
  output logic             testo_par_d
`endif
);

  pack_state_e           state_q, state_d;
  logic [SLOT_IDX_W-1:0] idx_q, idx_d;
  logic [BYTE_W-1:0]     acc_q, acc_d;
  logic [BYTE_W-1:0]     data_q, data_d;
  logic                  vld_q, vld_d;

  logic              accept;
  logic [SLOT_W-1:0] sample;

  assign testo_rdy_d = (state_q != StHold) || testi_rdy_d;
  assign accept      = testi_vld_d && testo_rdy_d;
  assign sample      = {testi1_d, testi2_d};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    data_d  = data_q;
    vld_d   = vld_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          acc_d   = place_slot('0, '0, sample);
          idx_d   = SLOT_IDX_W'(1);
          state_d = StFill;
        end
      end
      StFill: begin
        if (accept) begin
          if (idx_q == SLOT_IDX_W'(SLOTS_PER_BYTE - 1)) begin
            data_d  = place_slot(acc_q, idx_q, sample);
            vld_d   = 1'b1;
            acc_d   = '0;
            idx_d   = '0;
            state_d = StHold;
          end else begin
            acc_d = place_slot(acc_q, idx_q, sample);
            idx_d = idx_q + SLOT_IDX_W'(1);
          end
        end
      end
      StHold: begin
        if (testi_rdy_d) begin
          data_d = '0;
          vld_d  = 1'b0;
          // A sample arriving with the release starts the next byte without a bubble.
          if (accept) begin
            acc_d   = place_slot('0, '0, sample);
            idx_d   = SLOT_IDX_W'(1);
            state_d = StFill;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
        acc_d   = '0;
        data_d  = '0;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
    end
  end

  assign testo_data_d = data_q;
  assign testo_vld_d  = vld_q;

`ifdef SUB_D_PACK_PARITY_EN
  // data_q is zero whenever no byte is held, so parity is 0 there too.
  assign testo_par_d = ^data_q;
`endif

  sub_d_satcnt #(
    .CNT_W(CNT_W)
  ) u_satcnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (testi_clr_d),
    .inc  (accept && testi3_d),
    .count(testo_cnt_d)
  );

endmodule

// File: tb/tb_sub_d_pack.sv
// Scoreboard bench for sub_d_pack: stimulus pushes expected bytes, a monitor pops on handshake.
module tb_sub_d_pack;

  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             testi_vld_d;
  logic             testo_rdy_d;
  logic             testi1_d;
  logic             testi2_d;
  logic             testi3_d;
  logic             testi_clr_d;
  logic [7:0]       testo_data_d;
  logic             testo_vld_d;
  logic             testi_rdy_d;
  logic [CNT_W-1:0] testo_cnt_d;
`ifdef SUB_D_PACK_PARITY_EN
  logic             testo_par_d;
`endif

  sub_d_pack #(
    .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .testi_vld_d (testi_vld_d),
    .testo_rdy_d (testo_rdy_d),
    .testi1_d    (testi1_d),
    .testi2_d    (testi2_d),
    .testi3_d    (testi3_d),
    .testi_clr_d (testi_clr_d),
    .testo_data_d(testo_data_d),
    .testo_vld_d (testo_vld_d),
    .testi_rdy_d (testi_rdy_d),
    .testo_cnt_d (testo_cnt_d)
`ifdef SUB_D_PACK_PARITY_EN
    ,
    .testo_par_d (testo_par_d)
`endif
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_acc;
  int         m_idx;
  int         exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model of one accepted sample.
  task automatic model_accept(input logic a, input logic b, input logic ev);
    m_acc[m_idx*2 +: 2] = {a, b};
    m_idx++;
    if (m_idx == 4) begin
      exp_q.push_back(m_acc);
      m_acc = 8'h00;
      m_idx = 0;
    end
    if (testi_clr_d) exp_cnt = 0;
    else if (ev && exp_cnt < 3) exp_cnt++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic a, input logic b, input logic ev);
    bit acc;
    int n;
    testi_vld_d = 1'b1;
    testi1_d    = a;
    testi2_d    = b;
    testi3_d    = ev;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = testo_rdy_d;
      step();
      n++;
    end
    chk("accept_timeout", 32'(acc), 32'd1);
    if (acc) model_accept(a, b, ev);
    testi_vld_d = 1'b0;
    testi3_d    = 1'b0;
    chk("cnt_model", 32'(testo_cnt_d), 32'(exp_cnt));
  endtask

  // Monitor: pops and compares on every output handshake.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst) begin
      if (testo_vld_d) begin
        if (testi_rdy_d) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h expected none", testo_data_d);
          end else begin
            e = exp_q.pop_front();
            chk("byte", 32'(testo_data_d), 32'(e));
`ifdef SUB_D_PACK_PARITY_EN
            chk("parity", 32'(testo_par_d), 32'(^e));
`endif
          end
        end
      end else begin
        chk("idle_data_zero", 32'(testo_data_d), 32'h0);
`ifdef SUB_D_PACK_PARITY_EN
        chk("idle_par_zero", 32'(testo_par_d), 32'h0);
`endif
      end
    end
  end

  int cnt_tab[5] = '{1, 2, 3, 3, 3};

  initial begin
    rst         = 1'b1;
    testi_vld_d = 1'b0;
    testi1_d    = 1'b0;
    testi2_d    = 1'b0;
    testi3_d    = 1'b0;
    testi_clr_d = 1'b0;
    testi_rdy_d = 1'b1;
    m_acc       = 8'h00;
    m_idx       = 0;
    exp_cnt     = 0;

    // Reset state
    step();
    step();
    chk("rst_vld", 32'(testo_vld_d), 32'h0);
    chk("rst_data", 32'(testo_data_d), 32'h0);
    chk("rst_cnt", 32'(testo_cnt_d), 32'h0);
    rst = 1'b0;
    step();
    chk("rdy_after_rst", 32'(testo_rdy_d), 32'h1);

    // Back-to-back samples -> 0x36, valid one cycle after 4th accept
    send(1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    chk("b2b_vld", 32'(testo_vld_d), 32'h1);
    chk("b2b_data", 32'(testo_data_d), 32'h36);
`ifdef SUB_D_PACK_PARITY_EN
    chk("b2b_par", 32'(testo_par_d), 32'h0);
`endif
    step();
    chk("b2b_vld_drop", 32'(testo_vld_d), 32'h0);

    // Saturation 1,2,3,3,3; 5th sample lands with the release of byte 0x99
    send(1'b0, 1'b1, 1'b1);
    chk("sat0", 32'(testo_cnt_d), 32'(cnt_tab[0]));
    send(1'b1, 1'b0, 1'b1);
    chk("sat1", 32'(testo_cnt_d), 32'(cnt_tab[1]));
    send(1'b0, 1'b1, 1'b1);
    chk("sat2", 32'(testo_cnt_d), 32'(cnt_tab[2]));
    send(1'b1, 1'b0, 1'b1);
    chk("sat3", 32'(testo_cnt_d), 32'(cnt_tab[3]));
    chk("byte99_data", 32'(testo_data_d), 32'h99);
    send(1'b1, 1'b1, 1'b1);
    chk("sat4", 32'(testo_cnt_d), 32'(cnt_tab[4]));
    send(1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    chk("byte03_data", 32'(testo_data_d), 32'h03);
    step();

    // Clear beats a simultaneous counted event; packing continues
    testi_clr_d = 1'b1;
    send(1'b1, 1'b1, 1'b1);
    testi_clr_d = 1'b0;
    chk("clr_prio", 32'(testo_cnt_d), 32'h0);
    send(1'b1, 1'b1, 1'b1);
    chk("cnt_after_clr", 32'(testo_cnt_d), 32'h1);
    send(1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    chk("byte0f_data", 32'(testo_data_d), 32'h0F);
    step();
    testi_clr_d = 1'b1;
    step();
    testi_clr_d = 1'b0;
    exp_cnt = 0;
    chk("clr_alone", 32'(testo_cnt_d), 32'h0);

    // Hold for 5 cycles with a pending counted sample, then release with no bubble
    testi_rdy_d = 1'b0;
    send(1'b1, 1'b1, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b1, 1'b0);
    testi_vld_d = 1'b1;
    testi1_d    = 1'b1;
    testi2_d    = 1'b0;
    testi3_d    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_rdy", 32'(testo_rdy_d), 32'h0);
      chk("hold_vld", 32'(testo_vld_d), 32'h1);
      chk("hold_data", 32'(testo_data_d), 32'h63);
      chk("hold_cnt", 32'(testo_cnt_d), 32'h0);
    end
    testi_rdy_d = 1'b1;
    step();
    model_accept(1'b1, 1'b0, 1'b1);
    testi_vld_d = 1'b0;
    testi3_d    = 1'b0;
    chk("release_vld", 32'(testo_vld_d), 32'h0);
    chk("release_cnt", 32'(testo_cnt_d), 32'h1);
    send(1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    chk("byte02_data", 32'(testo_data_d), 32'h02);
    step();

    // Reset mid-fill discards partial byte
    send(1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    chk("midrst_vld", 32'(testo_vld_d), 32'h0);
    chk("midrst_cnt", 32'(testo_cnt_d), 32'h0);
    rst     = 1'b0;
    m_acc   = 8'h00;
    m_idx   = 0;
    exp_cnt = 0;
    for (int i = 0; i < 4; i++) send(1'b1, 1'b1, 1'b0);
    chk("byteff_data", 32'(testo_data_d), 32'hFF);
    step();
    step();
    step();

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
